// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss stopwatch and its countdown sibling:
// FSM encoding, BCD digit width and digit limits.
package timer_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] ONES_LIMIT = 4'd9;
   localparam logic [BCD_W-1:0] TENS_LIMIT = 4'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      FULL  = 2'd3
   } timer_state_e;

endpackage

// File: rtl/up_counter_digit.sv
// One BCD up-counter stage. It wraps to zero at its limit and raises a
// combinational carry so that the next stage steps on the same edge.
module up_counter_digit
   import timer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   input  logic             hold,
   input  logic [BCD_W-1:0] limit,
   output logic [BCD_W-1:0] value,
   output logic             carry
);

   // The carry ignores hold, so the top level can see a pending 59:59
   // rollover while it is suppressing the increment.
   assign carry = inc & (value == limit);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         value <= '0;
      end else if (inc && !hold) begin
         if (carry) begin
            value <= '0;
         end else begin
            value <= value + 4'd1;
         end
      end
   end

endmodule

// File: rtl/up_counter_mmss.sv
// mm:ss up-counting stopwatch: start/pause FSM gating a 1 Hz tick into a
// four-stage BCD carry chain, with saturate-or-wrap handling at 59:59.
module up_counter_mmss
   import timer_pkg::*;
#(
   parameter int WRAP           = 0,
   parameter int SEC_TENS_LIMIT = 5,
   parameter int MIN_TENS_LIMIT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start_pause,
   input  logic             clear,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             running,
   output logic             overflow,
   output logic [1:0]       state_dbg
);

   // tick, start_pause and clear are single-cycle strobes with no ready
   // side: each high cycle is one event, consumed at that clk edge.

   localparam logic WRAP_EN = (WRAP != 0);

   timer_state_e state, state_n;

   logic inc_so, inc_st, inc_mo, inc_mt, top_carry;
   logic carry_so, carry_st, carry_mo;
   logic hold;

   assign inc_so = tick & (state == RUN);
   assign inc_st = carry_so;
   assign inc_mo = carry_st;
   assign inc_mt = carry_mo;

   // Saturating mode freezes every stage on the 59:59 rollover edge.
   assign hold = top_carry & ~WRAP_EN;

   up_counter_digit u_sec_ones (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (inc_so),
      .hold  (hold),
      .limit (ONES_LIMIT),
      .value (sec_ones),
      .carry (carry_so)
   );

   up_counter_digit u_sec_tens (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (inc_st),
      .hold  (hold),
      .limit (4'(SEC_TENS_LIMIT)),
      .value (sec_tens),
      .carry (carry_st)
   );

   up_counter_digit u_min_ones (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (inc_mo),
      .hold  (hold),
      .limit (ONES_LIMIT),
      .value (min_ones),
      .carry (carry_mo)
   );

   up_counter_digit u_min_tens (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (inc_mt),
      .hold  (hold),
      .limit (4'(MIN_TENS_LIMIT)),
      .value (min_tens),
      .carry (top_carry)
   );

   always_comb begin
      state_n = state;
      if (clear) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_pause) state_n = RUN;
            end
            RUN: begin
               // Saturation outranks a coincident pause request.
               if (top_carry && !WRAP_EN) begin
                  state_n = FULL;
               end else if (start_pause) begin
                  state_n = PAUSE;
               end
            end
            PAUSE: begin
               if (start_pause) state_n = RUN;
            end
            FULL: begin
               state_n = FULL;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         running  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         running  <= (state_n == RUN);
         overflow <= top_carry & ~clear;
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_up_counter_mmss.sv
// Bench for up_counter_mmss: a saturating and a wrapping instance share one
// stimulus stream; directed vectors plus long count-up sequences.
module tb_up_counter_mmss;
   import timer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick = 1'b0;
   logic start_pause = 1'b0;
   logic clear = 1'b0;

   logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
   logic       run0, run1, ovf0, ovf1;
   logic [1:0] sd0, sd1;

   logic [15:0] dig [2];
   logic        run [2];
   logic        ovf [2];
   logic [1:0]  sta [2];

   assign dig[0] = {mt0, mo0, st0, so0};
   assign dig[1] = {mt1, mo1, st1, so1};
   assign run[0] = run0;
   assign run[1] = run1;
   assign ovf[0] = ovf0;
   assign ovf[1] = ovf1;
   assign sta[0] = sd0;
   assign sta[1] = sd1;

   up_counter_mmss #(.WRAP(0), .SEC_TENS_LIMIT(5), .MIN_TENS_LIMIT(5)) dut_sat (
      .clk (clk), .rst (rst), .tick (tick), .start_pause (start_pause), .clear (clear),
      .sec_ones (so0), .sec_tens (st0), .min_ones (mo0), .min_tens (mt0),
      .running (run0), .overflow (ovf0), .state_dbg (sd0)
   );

   up_counter_mmss #(.WRAP(1), .SEC_TENS_LIMIT(5), .MIN_TENS_LIMIT(5)) dut_wrap (
      .clk (clk), .rst (rst), .tick (tick), .start_pause (start_pause), .clear (clear),
      .sec_ones (so1), .sec_tens (st1), .min_ones (mo1), .min_tens (mt1),
      .running (run1), .overflow (ovf1), .state_dbg (sd1)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q [$];

   logic ovf_allowed = 1'b0;
   int   ovf_bad = 0;

   always @(negedge clk) begin
      if (!ovf_allowed && (ovf0 || ovf1)) ovf_bad++;
   end

   typedef struct {
      logic        r;
      logic        c;
      logic        t;
      logic        s;
      logic [15:0] e_dig;
      logic        e_run;
      logic [1:0]  e_st;
   } vec_t;

   vec_t vecs [25];

   function automatic logic [15:0] to_bcd(input int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int idx, input logic [15:0] e_dig,
                            input logic e_run, input logic e_ovf, input logic [1:0] e_st);
      check($sformatf("%s_d%0d_digits", tag, idx), dig[idx], e_dig);
      check($sformatf("%s_d%0d_running", tag, idx), 16'(run[idx]), 16'(e_run));
      check($sformatf("%s_d%0d_overflow", tag, idx), 16'(ovf[idx]), 16'(e_ovf));
      check($sformatf("%s_d%0d_state", tag, idx), 16'(sta[idx]), 16'(e_st));
   endtask

   // driver: one clock of strobes, outputs settled 1 ns after the edge
   task automatic cycle(input logic r, input logic c, input logic t, input logic s);
      @(negedge clk);
      rst = r;
      clear = c;
      tick = t;
      start_pause = s;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear = 1'b0;
      tick = 1'b0;
      start_pause = 1'b0;
   endtask

   task automatic set_vec(input int i, input logic r, input logic c, input logic t,
                          input logic s, input logic [15:0] d, input logic ru,
                          input logic [1:0] st);
      vecs[i].r = r;
      vecs[i].c = c;
      vecs[i].t = t;
      vecs[i].s = s;
      vecs[i].e_dig = d;
      vecs[i].e_run = ru;
      vecs[i].e_st = st;
   endtask

   initial begin
      int secs;

      //          r  c  t  s  digits    run st
      set_vec(0,  1, 0, 0, 0, 16'h0000, 0, 2'd0);
      set_vec(1,  1, 0, 0, 0, 16'h0000, 0, 2'd0);
      set_vec(2,  0, 0, 1, 0, 16'h0000, 0, 2'd0);
      set_vec(3,  0, 0, 1, 0, 16'h0000, 0, 2'd0);
      set_vec(4,  0, 0, 1, 0, 16'h0000, 0, 2'd0);
      set_vec(5,  0, 0, 0, 1, 16'h0000, 1, 2'd1);
      set_vec(6,  0, 0, 1, 0, 16'h0001, 1, 2'd1);
      set_vec(7,  0, 0, 1, 0, 16'h0002, 1, 2'd1);
      set_vec(8,  0, 0, 1, 0, 16'h0003, 1, 2'd1);
      set_vec(9,  0, 0, 0, 1, 16'h0003, 0, 2'd2);
      set_vec(10, 0, 0, 1, 0, 16'h0003, 0, 2'd2);
      set_vec(11, 0, 0, 1, 0, 16'h0003, 0, 2'd2);
      set_vec(12, 0, 0, 1, 0, 16'h0003, 0, 2'd2);
      set_vec(13, 0, 0, 1, 0, 16'h0003, 0, 2'd2);
      set_vec(14, 0, 0, 1, 0, 16'h0003, 0, 2'd2);
      set_vec(15, 0, 0, 0, 1, 16'h0003, 1, 2'd1);
      set_vec(16, 0, 0, 1, 0, 16'h0004, 1, 2'd1);
      set_vec(17, 0, 0, 1, 0, 16'h0005, 1, 2'd1);
      set_vec(18, 0, 0, 1, 0, 16'h0006, 1, 2'd1);
      set_vec(19, 0, 0, 1, 0, 16'h0007, 1, 2'd1);
      set_vec(20, 0, 0, 1, 1, 16'h0008, 0, 2'd2);
      set_vec(21, 0, 0, 1, 1, 16'h0008, 1, 2'd1);
      set_vec(22, 0, 1, 1, 0, 16'h0000, 0, 2'd0);
      set_vec(23, 0, 1, 0, 1, 16'h0000, 0, 2'd0);
      set_vec(24, 1, 0, 1, 1, 16'h0000, 0, 2'd0);

      for (int i = 0; i < 25; i++) begin
         cycle(vecs[i].r, vecs[i].c, vecs[i].t, vecs[i].s);
         for (int d = 0; d < 2; d++) begin
            check_dut($sformatf("vec%0d", i), d, vecs[i].e_dig, vecs[i].e_run, 1'b0, vecs[i].e_st);
         end
      end

      // carry chain through 00:10, 01:00 and on to 02:15, then clear+tick
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1);
      secs = 0;
      for (int i = 0; i < 135; i++) begin
         cycle(0, 0, 1, 0);
         secs++;
         exp_q.push_back(to_bcd(secs));
         for (int d = 0; d < 2; d++) check($sformatf("count_%0d_d%0d", secs, d), dig[d], exp_q[0]);
         void'(exp_q.pop_front());
         if (secs == 10) check("sec_tens_carry", dig[0], 16'h0010);
         if (secs == 60) check("min_ones_carry", dig[0], 16'h0100);
      end
      check("at_0215", dig[1], 16'h0215);
      cycle(0, 1, 1, 0);
      for (int d = 0; d < 2; d++) check_dut("clear_tick", d, 16'h0000, 1'b0, 1'b0, 2'd0);
      check("no_early_overflow", 16'(ovf_bad), 16'd0);

      // full range to 59:59 and the rollover edge
      cycle(1, 0, 0, 0);
      ovf_allowed = 1'b1;
      cycle(0, 0, 0, 1);
      for (int i = 1; i <= 3599; i++) begin
         cycle(0, 0, 1, 0);
         exp_q.push_back(to_bcd(i));
         for (int d = 0; d < 2; d++) check($sformatf("full_%0d_d%0d", i, d), dig[d], exp_q[0]);
         void'(exp_q.pop_front());
      end
      for (int d = 0; d < 2; d++) check_dut("at_5959", d, 16'h5959, 1'b1, 1'b0, 2'd1);

      cycle(0, 0, 1, 0);
      check_dut("rollover", 0, 16'h5959, 1'b0, 1'b1, 2'd3);
      check_dut("rollover", 1, 16'h0000, 1'b1, 1'b1, 2'd1);
      cycle(0, 0, 0, 0);
      check_dut("ovf_drop", 0, 16'h5959, 1'b0, 1'b0, 2'd3);
      check_dut("ovf_drop", 1, 16'h0000, 1'b1, 1'b0, 2'd1);
      cycle(0, 0, 1, 0);
      check_dut("post_tick", 0, 16'h5959, 1'b0, 1'b0, 2'd3);
      check_dut("post_tick", 1, 16'h0001, 1'b1, 1'b0, 2'd1);
      cycle(0, 0, 0, 1);
      check_dut("post_sp", 0, 16'h5959, 1'b0, 1'b0, 2'd3);
      check_dut("post_sp", 1, 16'h0001, 1'b0, 1'b0, 2'd2);
      cycle(0, 0, 1, 0);
      check_dut("pause_tick", 0, 16'h5959, 1'b0, 1'b0, 2'd3);
      check_dut("pause_tick", 1, 16'h0001, 1'b0, 1'b0, 2'd2);
      cycle(0, 1, 0, 0);
      for (int d = 0; d < 2; d++) check_dut("final_clear", d, 16'h0000, 1'b0, 1'b0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
